// File: rtl/register_file_pkg.sv
// Shared sizing defaults and type aliases for the multi-port register file slice.
package register_file_pkg;

    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned BUS_W_DEF  = 32;

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
    typedef logic [BUS_W_DEF-1:0]  reg_data_t;

    localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: issue reserves a destination, writeback retires it.
module rf_scoreboard
    import register_file_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned N_RD   = 2,
    parameter int unsigned BYPASS = 1
) (
    input  logic                          reloj,
    input  logic                          reset_n,
    input  logic [1:0]                    wr_en,
    input  logic [1:0][ADDR_W-1:0]        wr_addr,
    input  logic                          rsv_en,
    input  logic [ADDR_W-1:0]             rsv_addr,
    input  logic [N_RD-1:0][ADDR_W-1:0]   rd_addr,
    output logic [N_RD-1:0]               rd_busy,
    output logic [2**ADDR_W-1:0]          busy_vec
);

    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

    logic [2**ADDR_W-1:0] busy_nxt;

    function automatic logic wr_hits(input logic [ADDR_W-1:0] a);
        return (wr_en[0] && wr_addr[0] == a) || (wr_en[1] && wr_addr[1] == a);
    endfunction

    // Reservation is applied after retirement so a new producer overrides the retiring one.
    always_comb begin
        busy_nxt = busy_vec;
        for (int unsigned p = 0; p < 2; p++) begin
            if (wr_en[p]) busy_nxt[wr_addr[p]] = 1'b0;
        end
        if (rsv_en) busy_nxt[rsv_addr] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge reloj) begin
        if (!reset_n) busy_vec <= '0;
        else          busy_vec <= busy_nxt;
    end

    always_comb begin
        rd_busy = '0;
        for (int unsigned k = 0; k < N_RD; k++) begin
            rd_busy[k] = busy_vec[rd_addr[k]];
            if (BYPASS != 0 && wr_hits(rd_addr[k]) && !(rsv_en && rsv_addr == rd_addr[k]))
                rd_busy[k] = 1'b0;
            if (rd_addr[k] == ZERO_A) rd_busy[k] = 1'b0;
        end
    end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file: N_RD combinational reads, two prioritised writes, zero register.
module register_file_mp
    import register_file_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned BUS_W  = BUS_W_DEF,
    parameter int unsigned N_RD   = 2,
    parameter int unsigned BYPASS = 1
) (
    input  logic                          reloj,
    input  logic                          reset_n,
    input  logic [N_RD-1:0][ADDR_W-1:0]   rd_addr,
    output logic [N_RD-1:0][BUS_W-1:0]    rd_data,
    output logic [N_RD-1:0]               rd_busy,
    input  logic [1:0]                    wr_en,
    input  logic [1:0][ADDR_W-1:0]        wr_addr,
    input  logic [1:0][BUS_W-1:0]         wr_data,
    input  logic                          rsv_en,
    input  logic [ADDR_W-1:0]             rsv_addr,
    output logic [2**ADDR_W-1:0]          busy_vec
);

    localparam int unsigned       DEPTH  = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

    logic [BUS_W-1:0] mem [DEPTH];

    // Port 1 is applied last so it wins a same-address collision.
    always_ff @(posedge reloj) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            for (int unsigned p = 0; p < 2; p++) begin
                if (wr_en[p] && wr_addr[p] != ZERO_A) mem[wr_addr[p]] <= wr_data[p];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int unsigned k = 0; k < N_RD; k++) begin
            rd_data[k] = mem[rd_addr[k]];
            if (BYPASS != 0) begin
                for (int unsigned p = 0; p < 2; p++) begin
                    if (wr_en[p] && wr_addr[p] == rd_addr[k]) rd_data[k] = wr_data[p];
                end
            end
            if (rd_addr[k] == ZERO_A) rd_data[k] = '0;
        end
    end

    rf_scoreboard #(
        .ADDR_W (ADDR_W),
        .N_RD   (N_RD),
        .BYPASS (BYPASS)
    ) u_scoreboard (
        .reloj    (reloj),
        .reset_n  (reset_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .rd_addr  (rd_addr),
        .rd_busy  (rd_busy),
        .busy_vec (busy_vec)
    );

endmodule

// File: tb/tb_register_file_mp.sv
// Directed + randomized bench for register_file_mp, bypass and non-bypass builds side by side.
module tb_register_file_mp;

    logic                reloj = 1'b0;
    logic                reset_n;
    logic [1:0][4:0]     rd_addr;
    logic [1:0][31:0]    rd_data_b1, rd_data_b0;
    logic [1:0]          rd_busy_b1, rd_busy_b0;
    logic [1:0]          wr_en;
    logic [1:0][4:0]     wr_addr;
    logic [1:0][31:0]    wr_data;
    logic                rsv_en;
    logic [4:0]          rsv_addr;
    logic [31:0]         busy_vec_b1, busy_vec_b0;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    logic [31:0] m_mem  [32];
    logic        m_busy [32];

    always #5 reloj = ~reloj;

    register_file_mp #(.ADDR_W(5), .BUS_W(32), .N_RD(2), .BYPASS(1)) dut_b1 (
        .reloj(reloj), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data_b1),
        .rd_busy(rd_busy_b1), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(busy_vec_b1)
    );

    register_file_mp #(.ADDR_W(5), .BUS_W(32), .N_RD(2), .BYPASS(0)) dut_b0 (
        .reloj(reloj), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data_b0),
        .rd_busy(rd_busy_b0), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(busy_vec_b0)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic written_now(input int a);
        return (wr_en[0] && int'(wr_addr[0]) == a) || (wr_en[1] && int'(wr_addr[1]) == a);
    endfunction

    function automatic logic [31:0] exp_rd(input int a, input bit byp);
        if (a == 0) return 32'h0;
        if (byp && wr_en[1] && int'(wr_addr[1]) == a) return wr_data[1];
        if (byp && wr_en[0] && int'(wr_addr[0]) == a) return wr_data[0];
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input int a, input bit byp);
        if (a == 0) return 1'b0;
        if (byp && written_now(a) && !(rsv_en && int'(rsv_addr) == a)) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic logic [31:0] model_vec();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic model_edge();
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) begin m_mem[i] = '0; m_busy[i] = 1'b0; end
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (wr_en[p] && wr_addr[p] != 0) begin
                    m_mem[wr_addr[p]]  = wr_data[p];
                    m_busy[wr_addr[p]] = 1'b0;
                end
            end
            if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
        end
    endtask

    task automatic set_in(input bit rst_n, input logic [1:0] we, input int a0, input int a1,
                          input logic [31:0] d0, input logic [31:0] d1,
                          input bit rv, input int ra, input int r0, input int r1);
        reset_n    = rst_n;
        wr_en      = we;
        wr_addr[0] = 5'(a0);
        wr_addr[1] = 5'(a1);
        wr_data[0] = d0;
        wr_data[1] = d1;
        rsv_en     = rv;
        rsv_addr   = 5'(ra);
        rd_addr[0] = 5'(r0);
        rd_addr[1] = 5'(r1);
    endtask

    // Compare all outputs against the model, then advance one clock and update the model.
    task automatic step();
        #1;
        chk("busy_vec_b1", 64'(busy_vec_b1), 64'(model_vec()));
        chk("busy_vec_b0", 64'(busy_vec_b0), 64'(model_vec()));
        if (reset_n) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("rd_data_b1[%0d]", k), 64'(rd_data_b1[k]), 64'(exp_rd(int'(rd_addr[k]), 1'b1)));
                chk($sformatf("rd_data_b0[%0d]", k), 64'(rd_data_b0[k]), 64'(exp_rd(int'(rd_addr[k]), 1'b0)));
                chk($sformatf("rd_busy_b1[%0d]", k), 64'(rd_busy_b1[k]), 64'(exp_busy(int'(rd_addr[k]), 1'b1)));
                chk($sformatf("rd_busy_b0[%0d]", k), 64'(rd_busy_b0[k]), 64'(exp_busy(int'(rd_addr[k]), 1'b0)));
            end
        end
        @(posedge reloj);
        model_edge();
        #1;
    endtask

    task automatic idle(input int r0, input int r1);
        set_in(1'b1, 2'b00, 0, 0, 32'h0, 32'h0, 1'b0, 0, r0, r1);
    endtask

    initial begin
        set_in(1'b0, 2'b00, 0, 0, 32'h0, 32'h0, 1'b0, 0, 0, 0);
        for (int i = 0; i < 32; i++) begin m_mem[i] = '0; m_busy[i] = 1'b0; end
        @(posedge reloj);
        #1;

        // Reset clears stored data.
        set_in(1'b1, 2'b01, 5, 0, 32'hDEAD_BEEF, 32'h0, 1'b0, 0, 5, 0);
        step();
        set_in(1'b0, 2'b00, 0, 0, 32'h0, 32'h0, 1'b1, 6, 5, 0);
        step();
        idle(5, 0);
        #1;
        chk("reset_reg5", 64'(rd_data_b1[0]), 64'h0);
        chk("reset_busy", 64'(busy_vec_b1), 64'h0);
        step();

        // Dual-write collision: port 1 wins.
        set_in(1'b1, 2'b11, 7, 7, 32'h1111_1111, 32'h2222_2222, 1'b0, 0, 0, 0);
        step();
        idle(7, 0);
        #1;
        chk("collide_b1", 64'(rd_data_b1[0]), 64'h2222_2222);
        chk("collide_b0", 64'(rd_data_b0[0]), 64'h2222_2222);
        step();

        // Same-cycle bypass vs registered visibility.
        set_in(1'b1, 2'b01, 3, 0, 32'hA5A5_0003, 32'h0, 1'b0, 0, 0, 3);
        #1;
        chk("bypass_on", 64'(rd_data_b1[1]), 64'hA5A5_0003);
        chk("bypass_off", 64'(rd_data_b0[1]), 64'h0);
        step();
        idle(0, 3);
        #1;
        chk("bypass_off_next", 64'(rd_data_b0[1]), 64'hA5A5_0003);
        step();

        // Scoreboard reserve then retire.
        set_in(1'b1, 2'b00, 0, 0, 32'h0, 32'h0, 1'b1, 9, 9, 0);
        step();
        idle(9, 0);
        #1;
        chk("rsv_vec9", 64'(busy_vec_b1[9]), 64'h1);
        chk("rsv_rdbusy9", 64'(rd_busy_b1[0]), 64'h1);
        step();
        set_in(1'b1, 2'b01, 9, 0, 32'h0000_0909, 32'h0, 1'b0, 0, 9, 0);
        #1;
        chk("retire_byp_busy", 64'(rd_busy_b1[0]), 64'h0);
        chk("retire_nobyp_busy", 64'(rd_busy_b0[0]), 64'h1);
        step();
        idle(9, 0);
        #1;
        chk("retired_vec9", 64'(busy_vec_b1[9]), 64'h0);
        step();

        // Set and clear on the same register: set wins, data still stored.
        set_in(1'b1, 2'b00, 0, 0, 32'h0, 32'h0, 1'b1, 4, 0, 0);
        step();
        set_in(1'b1, 2'b10, 0, 4, 32'h0, 32'h4444_0004, 1'b1, 4, 4, 0);
        step();
        idle(4, 0);
        #1;
        chk("setclr_vec4", 64'(busy_vec_b1[4]), 64'h1);
        chk("setclr_data4", 64'(rd_data_b0[0]), 64'h4444_0004);
        step();

        // Zero register ignores writes and reservations.
        set_in(1'b1, 2'b11, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, 0, 0);
        #1;
        chk("zero_rd_b1", 64'(rd_data_b1), 64'h0);
        chk("zero_rd_b0", 64'(rd_data_b0), 64'h0);
        chk("zero_busy", 64'({rd_busy_b1, rd_busy_b0}), 64'h0);
        step();
        idle(0, 0);
        #1;
        chk("zero_vec0", 64'(busy_vec_b1[0]), 64'h0);
        chk("zero_rd_next", 64'(rd_data_b0[0]), 64'h0);
        step();

        // Random traffic; narrow address range half the time to provoke collisions.
        for (int n = 0; n < 400; n++) begin
            int lim;
            lim = ($urandom_range(0, 1) != 0) ? 7 : 31;
            set_in(($urandom_range(0, 49) != 0), 2'($urandom_range(0, 3)),
                   int'($urandom_range(0, lim)), int'($urandom_range(0, lim)),
                   $urandom(), $urandom(), ($urandom_range(0, 2) == 0),
                   int'($urandom_range(0, lim)), int'($urandom_range(0, lim)),
                   int'($urandom_range(0, lim)));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Parametrised multi-port successor to the single-write, two-read register file in the core datapath.
- Configurable read-port count, two write ports and a hardwired zero register.
- Optional same-cycle write-to-read bypass.
- Per-register busy scoreboard: the issue stage reserves a destination and the writeback clears it, so hazard stalls are decided locally.

Parameters:
- ADDR_W, 5, register address width; depth DEPTH = 2**ADDR_W.
- BUS_W, 32, data width.
- N_RD, 2, number of read ports, range 1..4.
- BYPASS, 1, 1 = read of a register being written this cycle returns the write data; 0 = returns the stored value.

Ports:
- reloj  input  1  clock; all state updates on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- rd_addr  input  [N_RD-1:0][ADDR_W-1:0]  read addresses.
- rd_data  output  [N_RD-1:0][BUS_W-1:0]  read data, combinational.
- rd_busy  output  [N_RD-1:0]  addressed register has a pending reservation.
- wr_en  input  [1:0]  write enables, port 1 has priority over port 0.
- wr_addr  input  [1:0][ADDR_W-1:0]  write addresses.
- wr_data  input  [1:0][BUS_W-1:0]  write data.
- rsv_en  input  1  reserve request from issue.
- rsv_addr  input  [ADDR_W-1:0]  register to mark busy.
- busy_vec  output  [DEPTH-1:0]  full scoreboard, registered.

Behaviour:
- Reset (reset_n low at rising edge of reloj):
  - all registers cleared to 0; busy_vec cleared to 0.
  - During reset, write and reserve inputs are ignored.
  - Reads remain combinational, so rd_data reflects the cleared array from the next cycle.
  - Reset asserted mid-operation discards any same-cycle write or reserve.
- Register 0:
  - reads always return 0 and rd_busy = 0.
  - writes and reserves to address 0 are dropped.
  - busy_vec[0] is always 0.
- Writes:
  - On each edge, every enabled port with a nonzero address stores wr_data.
  - Both ports to the same address: port 1 data is stored.
- Read:
  - rd_data[k] = stored value of reg_mem[rd_addr[k]], zero-cycle latency.
  - With BYPASS=1, if a write port is enabled to a nonzero rd_addr[k] this cycle, rd_data[k] = that wr_data instead (port 1 over port 0).
  - With BYPASS=0, the new value is visible the cycle after the write.
- Scoreboard, per register r != 0, evaluated at each edge:
  - set when rsv_en and rsv_addr == r.
  - clear when any enabled write port addresses r.
  - set and clear in the same cycle: set wins, because the new producer supersedes the retiring one.
  - reserving an already-busy register leaves it busy; no counting, one outstanding producer per register.
  - writing a non-busy register is legal; data is stored and busy stays 0.
- rd_busy[k] = busy_vec[rd_addr[k]], adjusted for same-cycle retirement:
  - With BYPASS=1, a register being written this cycle (and not reserved this cycle) reports rd_busy = 0.
  - With BYPASS=0, it reports the registered value.
- No internal FSM beyond the array and scoreboard; no handshake back-pressure. The consumer stalls on rd_busy.

Decomposition:
- Package register_file_pkg holds:
  - default constants for ADDR_W and BUS_W;
  - typedef reg_addr_t and reg_data_t;
  - constant ZERO_REG = '0.
- One natural sub-module: rf_scoreboard.
  - Holds the busy_vec flops and the set/clear priority logic.
  - Exposes a per-port busy lookup with retirement bypass.
- Data array, write priority and read bypass stay in the top module.

Test Plan:
- Reset: write reg 5 = 32'hDEAD_BEEF, then reset_n = 0 for one cycle -> reg 5 reads 0; busy_vec = 0.
- Dual write collision: wr_en = 2'b11, both addresses = 7, wr_data = {32'h2222_2222, 32'h1111_1111} -> next cycle reg 7 reads 32'h2222_2222.
- Bypass: BYPASS=1, wr_en[0] = 1, wr_addr[0] = 3, wr_data[0] = 32'hA5A5_0003, rd_addr[1] = 3 in the same cycle -> rd_data[1] = 32'hA5A5_0003 combinationally. Repeat with BYPASS=0 -> old value this cycle, new value next cycle.
- Scoreboard life cycle:
  - rsv_en, rsv_addr = 9 -> busy_vec[9] = 1 next cycle; rd_busy = 1 on a port reading 9.
  - Write to 9 -> rd_busy = 0 in the write cycle (BYPASS=1); busy_vec[9] = 0 after the edge.
- Set/clear collision: reg 4 busy; in one cycle rsv_addr = 4 and wr_addr[1] = 4 -> data stored; busy_vec[4] stays 1.
- Zero register: write 32'hFFFF_FFFF to 0 and reserve 0 -> all ports read 0 at address 0; rd_busy = 0; busy_vec[0] = 0.
